iiq_issue_scheduler: RTL and testbench

Select and wakeup controller for the integer issue queue, a shift queue holding age-ordered micro-ops with entry 0 the oldest. Each cycle the scheduler does four things: it snoops CDB result tags and writes source-ready bits back into waiting entries, it patches ready bits on the enqueue path, it selects the oldest ready entry whose functional unit can accept it, and it dequeues that entry into a one-entry issue register. The issue register hands off to execute with a valid/ready handshake. The scheduler also tracks occupancy of the unpipelined divider.

---
 rtl/iiq_pkg.sv | 36 +++
 rtl/iiq_oldest_select.sv | 23 ++
 rtl/iiq_issue_scheduler.sv | 158 +++++++++++++++
 tb/tb_iiq_issue_scheduler.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iiq_pkg.sv
// Shared types and widths for the integer issue queue scheduler.
// Widths follow `IIQ_N_ENTRIES and `PHYS_REG_TAG_WIDTH when the build provides them.
`ifndef IIQ_N_ENTRIES
`define IIQ_N_ENTRIES 4
`endif
`ifndef PHYS_REG_TAG_WIDTH
`define PHYS_REG_TAG_WIDTH 6
`endif

package iiq_pkg;

  localparam int unsigned N_ENTRIES       = `IIQ_N_ENTRIES;
  localparam int unsigned TAG_WIDTH       = `PHYS_REG_TAG_WIDTH;
  localparam int unsigned PAYLOAD_WIDTH   = 16;
  localparam int unsigned DIV_LAT_DEFAULT = 16;

  typedef enum logic [1:0] {
    FuAlu = 2'd0,
    FuMul = 2'd1,
    FuDiv = 2'd2
  } fu_type_e;

  typedef struct packed {
    logic                     src1_rdy;
    logic [TAG_WIDTH-1:0]     src1_tag;
    logic                     src2_rdy;
    logic [TAG_WIDTH-1:0]     src2_tag;
    fu_type_e                 fu_type;
    logic [TAG_WIDTH-1:0]     dst_tag;
    logic [PAYLOAD_WIDTH-1:0] payload;
  } iiq_entry_t;

  localparam int unsigned ENTRY_WIDTH = $bits(iiq_entry_t);
  localparam int unsigned CTR_WIDTH   = $clog2(N_ENTRIES + 1);

endpackage

// File: rtl/iiq_oldest_select.sv
// Combinational pick-first: one-hot of the lowest-index set bit, or all zeros.

module iiq_oldest_select #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] elig_i,
  output logic [N-1:0] sel_onehot_o
);

  logic found;

  always_comb begin
    sel_onehot_o = '0;
    found        = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (elig_i[i] && !found) begin
        sel_onehot_o[i] = 1'b1;
        found           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/iiq_issue_scheduler.sv
// Wakeup, oldest-ready select and one-entry issue register for the integer issue queue.
// Defining IIQ_SCHED_PERF_EN adds 32-bit issue and stall performance counters.

module iiq_issue_scheduler
  import iiq_pkg::*;
#(
  parameter int unsigned N_CDB   = 2,
  parameter int unsigned DIV_LAT = DIV_LAT_DEFAULT
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             flush_i,
  input  logic [N_CDB-1:0]                 cdb_valid_i,
  input  logic [N_CDB*TAG_WIDTH-1:0]       cdb_tag_i,
  input  logic                             in_enq_valid_i,
  input  logic [ENTRY_WIDTH-1:0]           in_enq_data_i,
  output logic                             in_enq_ready_o,
  output logic                             q_enq_valid_o,
  output logic [ENTRY_WIDTH-1:0]           q_enq_data_o,
  input  logic                             q_enq_ready_i,
  input  logic [N_ENTRIES*ENTRY_WIDTH-1:0] q_entry_douts_i,
  input  logic [CTR_WIDTH-1:0]             q_count_i,
  output logic [N_ENTRIES-1:0]             q_deq_sel_onehot_o,
  output logic                             q_deq_ready_o,
  output logic [N_ENTRIES-1:0]             q_wr_en_o,
  output logic [N_ENTRIES*ENTRY_WIDTH-1:0] q_wr_data_o,
  output logic                             iss_valid_o,
  output logic [ENTRY_WIDTH-1:0]           iss_data_o,
  input  logic                             iss_ready_i,
  output logic [$clog2(DIV_LAT+1)-1:0]     div_ctr_o
`ifdef IIQ_SCHED_PERF_EN
  ,
  output logic [31:0]                      perf_issue_ctr_o,
  output logic [31:0]                      perf_stall_ctr_o
`endif
);

  localparam int unsigned DivCtrW = $clog2(DIV_LAT + 1);

  iiq_entry_t           entries [N_ENTRIES];
  iiq_entry_t           woken   [N_ENTRIES];
  iiq_entry_t           sel_entry;
  logic [N_ENTRIES-1:0] valid, elig, pick;
  logic                 div_block, slot_free, deq_allowed, accept;

  logic               iss_valid_q, iss_valid_d;
  iiq_entry_t         iss_data_q, iss_data_d;
  logic [DivCtrW-1:0] div_ctr_q, div_ctr_d;

  // Sets the rdy bit of any source whose tag is on a valid CDB bus this cycle.
  function automatic iiq_entry_t wake(input iiq_entry_t e, input logic [N_CDB-1:0] v,
                                      input logic [N_CDB*TAG_WIDTH-1:0] tags);
    iiq_entry_t r;
    r = e;
    for (int k = 0; k < N_CDB; k++) begin
      if (v[k] && tags[k*TAG_WIDTH +: TAG_WIDTH] == e.src1_tag) r.src1_rdy = 1'b1;
      if (v[k] && tags[k*TAG_WIDTH +: TAG_WIDTH] == e.src2_tag) r.src2_rdy = 1'b1;
    end
    return r;
  endfunction

  assign div_block = (div_ctr_q != '0) || (iss_valid_q && iss_data_q.fu_type == FuDiv);

  // Eligibility uses stored rdy bits only; same-cycle wakeups count from next cycle.
  always_comb begin
    q_wr_en_o   = '0;
    q_wr_data_o = '0;
    valid       = '0;
    elig        = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      entries[i] = iiq_entry_t'(q_entry_douts_i[i*ENTRY_WIDTH +: ENTRY_WIDTH]);
      woken[i]   = wake(entries[i], cdb_valid_i, cdb_tag_i);
      valid[i]   = CTR_WIDTH'(i) < q_count_i;
      q_wr_en_o[i] = valid[i] &&
                     ((woken[i].src1_rdy && !entries[i].src1_rdy) ||
                      (woken[i].src2_rdy && !entries[i].src2_rdy));
      q_wr_data_o[i*ENTRY_WIDTH +: ENTRY_WIDTH] = woken[i];
      elig[i] = valid[i] && entries[i].src1_rdy && entries[i].src2_rdy &&
                !(entries[i].fu_type == FuDiv && div_block);
    end
  end

  iiq_oldest_select #(
    .N (N_ENTRIES)
  ) u_oldest_select (
    .elig_i       (elig),
    .sel_onehot_o (pick)
  );

  assign slot_free          = !iss_valid_q || iss_ready_i;
  assign deq_allowed        = slot_free && !flush_i && !rst_i;
  assign q_deq_sel_onehot_o = deq_allowed ? pick : '0;
  assign q_deq_ready_o      = |q_deq_sel_onehot_o;
  assign accept             = iss_valid_q && iss_ready_i;

  always_comb begin
    sel_entry = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (q_deq_sel_onehot_o[i]) sel_entry = entries[i];
    end
  end

  assign q_enq_valid_o  = in_enq_valid_i;
  assign q_enq_data_o   = wake(iiq_entry_t'(in_enq_data_i), cdb_valid_i, cdb_tag_i);
  assign in_enq_ready_o = q_enq_ready_i;

  always_comb begin
    iss_valid_d = iss_valid_q;
    iss_data_d  = iss_data_q;
    div_ctr_d   = div_ctr_q;
    if (q_deq_ready_o) begin
      iss_valid_d = 1'b1;
      iss_data_d  = sel_entry;
    end else if (flush_i || accept) begin
      iss_valid_d = 1'b0;
    end
    // The divider stays busy across a flush, so only acceptance reloads the counter.
    if (accept && iss_data_q.fu_type == FuDiv) begin
      div_ctr_d = DivCtrW'(DIV_LAT - 1);
    end else if (div_ctr_q != '0) begin
      div_ctr_d = div_ctr_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      iss_valid_q <= 1'b0;
      iss_data_q  <= '0;
      div_ctr_q   <= '0;
    end else begin
      iss_valid_q <= iss_valid_d;
      iss_data_q  <= iss_data_d;
      div_ctr_q   <= div_ctr_d;
    end
  end

  assign iss_valid_o = iss_valid_q;
  assign iss_data_o  = iss_data_q;
  assign div_ctr_o   = div_ctr_q;

`ifdef IIQ_SCHED_PERF_EN
  logic [31:0] perf_issue_q, perf_stall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_issue_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (accept) perf_issue_q <= perf_issue_q + 32'd1;
      if (q_count_i != '0 && !q_deq_ready_o) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_issue_ctr_o = perf_issue_q;
  assign perf_stall_ctr_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_iiq_issue_scheduler.sv
// Directed bench for iiq_issue_scheduler: queue contents are driven by hand each cycle.

module tb_iiq_issue_scheduler;
  import iiq_pkg::*;

  localparam int unsigned NC = 2;
  localparam int unsigned DL = 16;
  localparam int unsigned W  = ENTRY_WIDTH;
  localparam int unsigned DW = $clog2(DL + 1);

  logic                   clk = 1'b0;
  logic                   rst, flush, in_enq_valid, in_enq_ready, q_enq_valid, q_enq_ready;
  logic [NC-1:0]          cdb_valid;
  logic [NC*TAG_WIDTH-1:0] cdb_tag;
  logic [W-1:0]           in_enq_data, q_enq_data, iss_data;
  logic [N_ENTRIES*W-1:0] q_entry_douts, q_wr_data;
  logic [CTR_WIDTH-1:0]   q_count;
  logic [N_ENTRIES-1:0]   q_deq_sel, q_wr_en;
  logic                   q_deq_ready, iss_valid, iss_ready;
  logic [DW-1:0]          div_ctr;
`ifdef IIQ_SCHED_PERF_EN
  logic [31:0]            perf_issue, perf_stall;
`endif

  iiq_entry_t qe [N_ENTRIES];
  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  always_comb begin
    q_entry_douts = '0;
    for (int i = 0; i < N_ENTRIES; i++) q_entry_douts[i*W +: W] = qe[i];
  end

  iiq_issue_scheduler #(.N_CDB(NC), .DIV_LAT(DL)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .flush_i            (flush),
    .cdb_valid_i        (cdb_valid),
    .cdb_tag_i          (cdb_tag),
    .in_enq_valid_i     (in_enq_valid),
    .in_enq_data_i      (in_enq_data),
    .in_enq_ready_o     (in_enq_ready),
    .q_enq_valid_o      (q_enq_valid),
    .q_enq_data_o       (q_enq_data),
    .q_enq_ready_i      (q_enq_ready),
    .q_entry_douts_i    (q_entry_douts),
    .q_count_i          (q_count),
    .q_deq_sel_onehot_o (q_deq_sel),
    .q_deq_ready_o      (q_deq_ready),
    .q_wr_en_o          (q_wr_en),
    .q_wr_data_o        (q_wr_data),
    .iss_valid_o        (iss_valid),
    .iss_data_o         (iss_data),
    .iss_ready_i        (iss_ready),
    .div_ctr_o          (div_ctr)
`ifdef IIQ_SCHED_PERF_EN
    ,
    .perf_issue_ctr_o   (perf_issue),
    .perf_stall_ctr_o   (perf_stall)
`endif
  );

  function automatic iiq_entry_t mk(input logic r1, input logic [TAG_WIDTH-1:0] t1,
                                    input logic r2, input logic [TAG_WIDTH-1:0] t2,
                                    input fu_type_e fu, input logic [15:0] pl);
    iiq_entry_t e;
    e.src1_rdy = r1;
    e.src1_tag = t1;
    e.src2_rdy = r2;
    e.src2_tag = t2;
    e.fu_type  = fu;
    e.dst_tag  = pl[TAG_WIDTH-1:0];
    e.payload  = pl;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < N_ENTRIES; i++) qe[i] = '0;
    q_count      = '0;
    cdb_valid    = '0;
    cdb_tag      = '0;
    flush        = 1'b0;
    iss_ready    = 1'b1;
    in_enq_valid = 1'b0;
    in_enq_data  = '0;
    q_enq_ready  = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst   = 1'b1;
    qe[0] = mk(1'b0, 6'd0, 1'b1, 6'd0, FuAlu, 16'h1110);
    qe[1] = mk(1'b1, 6'd2, 1'b1, 6'd3, FuAlu, 16'h1111);
    cdb_valid = 2'b11;
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_total++; if (iss_valid !== 1'b0) $display("FAIL reset_iss_valid: got %b expected 0", iss_valid); else n_pass++;
    n_total++; if (iss_data !== '0) $display("FAIL reset_iss_data: got %h expected 0", iss_data); else n_pass++;
    n_total++; if (div_ctr !== '0) $display("FAIL reset_div_ctr: got %0d expected 0", div_ctr); else n_pass++;
    n_total++; if (q_deq_sel !== 4'b0000) $display("FAIL empty_deq_sel: got %b expected 0000", q_deq_sel); else n_pass++;
    n_total++; if (q_deq_ready !== 1'b0) $display("FAIL empty_deq_ready: got %b expected 0", q_deq_ready); else n_pass++;
    n_total++; if (q_wr_en !== 4'b0000) $display("FAIL empty_wr_en: got %b expected 0000", q_wr_en); else n_pass++;
    clear_inputs();
    tick();
  endtask

  task automatic test_wakeup_select();
    iiq_entry_t w0;
    clear_inputs();
    qe[0] = mk(1'b0, 6'd5, 1'b1, 6'd1, FuAlu, 16'hA000);
    qe[1] = mk(1'b0, 6'd5, 1'b1, 6'd1, FuAlu, 16'hA001);
    w0    = mk(1'b1, 6'd5, 1'b1, 6'd1, FuAlu, 16'hA000);
    q_count   = 3'd1;
    cdb_valid = 2'b01;
    cdb_tag   = {6'd0, 6'd5};
    #1;
    n_total++; if (q_wr_en !== 4'b0001) $display("FAIL wake_wr_en: got %b expected 0001", q_wr_en); else n_pass++;
    n_total++; if (iiq_entry_t'(q_wr_data[W-1:0]) !== w0) $display("FAIL wake_wr_data: got %h expected %h", q_wr_data[W-1:0], w0); else n_pass++;
    n_total++; if (q_deq_sel !== 4'b0000) $display("FAIL wake_same_cycle_sel: got %b expected 0000", q_deq_sel); else n_pass++;
    tick();
    qe[0] = w0;
    cdb_valid = '0;
    #1;
    n_total++; if (q_deq_sel !== 4'b0001) $display("FAIL wake_next_sel: got %b expected 0001", q_deq_sel); else n_pass++;
    n_total++; if (q_deq_ready !== 1'b1) $display("FAIL wake_deq_ready: got %b expected 1", q_deq_ready); else n_pass++;
    n_total++; if (iss_valid !== 1'b0) $display("FAIL wake_iss_early: got %b expected 0", iss_valid); else n_pass++;
    tick();
    clear_inputs();
    #1;
    n_total++; if (iss_valid !== 1'b1) $display("FAIL wake_iss_valid: got %b expected 1", iss_valid); else n_pass++;
    n_total++; if (iiq_entry_t'(iss_data) !== w0) $display("FAIL wake_iss_data: got %h expected %h", iss_data, w0); else n_pass++;
    tick();
    n_total++; if (iss_valid !== 1'b0) $display("FAIL wake_iss_clear: got %b expected 0", iss_valid); else n_pass++;
  endtask

  task automatic test_age_priority();
    iiq_entry_t e0, e1, e2, e3;
    clear_inputs();
    e0 = mk(1'b0, 6'd20, 1'b1, 6'd0, FuAlu, 16'hB000);
    e1 = mk(1'b1, 6'd1, 1'b1, 6'd2, FuAlu, 16'hB001);
    e2 = mk(1'b1, 6'd3, 1'b0, 6'd21, FuAlu, 16'hB002);
    e3 = mk(1'b1, 6'd4, 1'b1, 6'd5, FuMul, 16'hB003);
    qe[0] = e0; qe[1] = e1; qe[2] = e2; qe[3] = e3;
    q_count = 3'd4;
    #1;
    n_total++; if (q_deq_sel !== 4'b0010) $display("FAIL age_sel_first: got %b expected 0010", q_deq_sel); else n_pass++;
    tick();
    qe[0] = e0; qe[1] = e2; qe[2] = e3; qe[3] = '0;
    q_count = 3'd3;
    #1;
    n_total++; if (iiq_entry_t'(iss_data) !== e1) $display("FAIL age_iss_first: got %h expected %h", iss_data, e1); else n_pass++;
    n_total++; if (q_deq_sel !== 4'b0100) $display("FAIL age_sel_shifted: got %b expected 0100", q_deq_sel); else n_pass++;
    tick();
    qe[2] = '0;
    q_count = 3'd2;
    #1;
    n_total++; if (iss_valid !== 1'b1 || iiq_entry_t'(iss_data) !== e3) $display("FAIL age_iss_second: got %b/%h expected 1/%h", iss_valid, iss_data, e3); else n_pass++;
    n_total++; if (q_deq_sel !== 4'b0000) $display("FAIL age_none_ready: got %b expected 0000", q_deq_sel); else n_pass++;
    clear_inputs();
    tick();
  endtask

  task automatic test_backpressure();
    iiq_entry_t e0, e1;
    clear_inputs();
    iss_ready = 1'b0;
    e0 = mk(1'b1, 6'd1, 1'b1, 6'd1, FuAlu, 16'hC000);
    e1 = mk(1'b1, 6'd1, 1'b1, 6'd1, FuMul, 16'hC001);
    qe[0] = e0; qe[1] = e1;
    q_count = 3'd2;
    #1;
    n_total++; if (q_deq_sel !== 4'b0001) $display("FAIL bp_first_sel: got %b expected 0001", q_deq_sel); else n_pass++;
    tick();
    qe[0] = e1; qe[1] = '0;
    q_count = 3'd1;
    #1;
    n_total++; if (iiq_entry_t'(iss_data) !== e0) $display("FAIL bp_iss_data: got %h expected %h", iss_data, e0); else n_pass++;
    n_total++; if (q_deq_ready !== 1'b0) $display("FAIL bp_deq_blocked: got %b expected 0", q_deq_ready); else n_pass++;
    tick();
    n_total++; if (iss_valid !== 1'b1 || iiq_entry_t'(iss_data) !== e0) $display("FAIL bp_iss_stable: got %b/%h expected 1/%h", iss_valid, iss_data, e0); else n_pass++;
    n_total++; if (q_deq_ready !== 1'b0) $display("FAIL bp_deq_still_blocked: got %b expected 0", q_deq_ready); else n_pass++;
    iss_ready = 1'b1;
    #1;
    n_total++; if (q_deq_sel !== 4'b0001) $display("FAIL bp_refill_sel: got %b expected 0001", q_deq_sel); else n_pass++;
    tick();
    qe[0] = '0;
    q_count = '0;
    #1;
    n_total++; if (iss_valid !== 1'b1 || iiq_entry_t'(iss_data) !== e1) $display("FAIL bp_refill_data: got %b/%h expected 1/%h", iss_valid, iss_data, e1); else n_pass++;
    tick();
    n_total++; if (iss_valid !== 1'b0) $display("FAIL bp_drain: got %b expected 0", iss_valid); else n_pass++;
  endtask

  // Leaves div_ctr at DL-1 on exit (second DIV accepted on the last cycle).
  task automatic test_div_occupancy();
    iiq_entry_t d1, d2, a;
    clear_inputs();
    d1 = mk(1'b1, 6'd1, 1'b1, 6'd2, FuDiv, 16'hD001);
    d2 = mk(1'b1, 6'd3, 1'b1, 6'd4, FuDiv, 16'hD002);
    a  = mk(1'b1, 6'd5, 1'b1, 6'd6, FuAlu, 16'hD003);
    qe[0] = d1;
    q_count = 3'd1;
    #1;
    n_total++; if (q_deq_sel !== 4'b0001) $display("FAIL div_first_sel: got %b expected 0001", q_deq_sel); else n_pass++;
    tick();
    qe[0] = d2; qe[1] = a;
    q_count = 3'd2;
    #1;
    n_total++; if (q_deq_sel !== 4'b0010) $display("FAIL div_alu_bypass: got %b expected 0010", q_deq_sel); else n_pass++;
    tick();
    qe[1] = '0;
    q_count = 3'd1;
    #1;
    n_total++; if (div_ctr !== DW'(DL - 1)) $display("FAIL div_ctr_load: got %0d expected %0d", div_ctr, DL - 1); else n_pass++;
    n_total++; if (iiq_entry_t'(iss_data) !== a) $display("FAIL div_alu_issued: got %h expected %h", iss_data, a); else n_pass++;
    n_total++; if (q_deq_sel !== 4'b0000) $display("FAIL div_busy_sel_1: got %b expected 0000", q_deq_sel); else n_pass++;
    for (int k = 2; k < int'(DL); k++) begin
      tick();
      n_total++; if (div_ctr !== DW'(DL - k)) $display("FAIL div_ctr_count_%0d: got %0d expected %0d", k, div_ctr, DL - k); else n_pass++;
      n_total++; if (q_deq_sel !== 4'b0000) $display("FAIL div_busy_sel_%0d: got %b expected 0000", k, q_deq_sel); else n_pass++;
    end
    tick();
    n_total++; if (div_ctr !== '0) $display("FAIL div_ctr_done: got %0d expected 0", div_ctr); else n_pass++;
    n_total++; if (q_deq_sel !== 4'b0001) $display("FAIL div_second_sel: got %b expected 0001", q_deq_sel); else n_pass++;
    tick();
    qe[0] = '0;
    q_count = '0;
    #1;
    n_total++; if (iss_valid !== 1'b1 || iiq_entry_t'(iss_data) !== d2) $display("FAIL div_second_iss: got %b/%h expected 1/%h", iss_valid, iss_data, d2); else n_pass++;
    tick();
    n_total++; if (div_ctr !== DW'(DL - 1)) $display("FAIL div_ctr_reload: got %0d expected %0d", div_ctr, DL - 1); else n_pass++;
  endtask

  // Entered with div_ctr = DL-1; leaves it at DL-5 after the final tick.
  task automatic test_flush();
    iiq_entry_t w, r;
    clear_inputs();
    iss_ready = 1'b0;
    qe[0] = mk(1'b1, 6'd7, 1'b1, 6'd8, FuAlu, 16'hE000);
    q_count = 3'd1;
    #1;
    n_total++; if (q_deq_sel !== 4'b0001) $display("FAIL flush_pre_sel: got %b expected 0001", q_deq_sel); else n_pass++;
    tick();
    w = mk(1'b1, 6'd7, 1'b0, 6'd9, FuAlu, 16'hE001);
    r = mk(1'b1, 6'd1, 1'b1, 6'd1, FuAlu, 16'hE002);
    qe[0] = w; qe[1] = r;
    q_count   = 3'd2;
    flush     = 1'b1;
    cdb_valid = 2'b10;
    cdb_tag   = {6'd9, 6'd0};
    #1;
    n_total++; if (q_wr_en !== 4'b0001) $display("FAIL flush_wakeup_1: got %b expected 0001", q_wr_en); else n_pass++;
    tick();
    n_total++; if (iss_valid !== 1'b0) $display("FAIL flush_iss_clear: got %b expected 0", iss_valid); else n_pass++;
    n_total++; if (div_ctr !== DW'(DL - 3)) $display("FAIL flush_div_ctr: got %0d expected %0d", div_ctr, DL - 3); else n_pass++;
    n_total++; if (q_deq_sel !== 4'b0000) $display("FAIL flush_no_deq: got %b expected 0000", q_deq_sel); else n_pass++;
    n_total++; if (q_wr_en !== 4'b0001) $display("FAIL flush_wakeup_2: got %b expected 0001", q_wr_en); else n_pass++;
    tick();
    flush     = 1'b0;
    cdb_valid = '0;
    #1;
    n_total++; if (iss_valid !== 1'b0) $display("FAIL flush_no_load: got %b expected 0", iss_valid); else n_pass++;
    n_total++; if (q_deq_sel !== 4'b0010) $display("FAIL flush_resume_sel: got %b expected 0010", q_deq_sel); else n_pass++;
    clear_inputs();
    #1;
    tick();
  endtask

  task automatic test_reset_mid_div();
    iiq_entry_t d3;
    clear_inputs();
    d3 = mk(1'b1, 6'd1, 1'b1, 6'd1, FuDiv, 16'hF000);
    qe[0] = d3;
    q_count = 3'd1;
    #1;
    n_total++; if (div_ctr !== DW'(DL - 5)) $display("FAIL rst_pre_div_ctr: got %0d expected %0d", div_ctr, DL - 5); else n_pass++;
    n_total++; if (q_deq_sel !== 4'b0000) $display("FAIL rst_pre_sel: got %b expected 0000", q_deq_sel); else n_pass++;
    rst   = 1'b1;
    flush = 1'b1;
    tick();
    rst   = 1'b0;
    flush = 1'b0;
    #1;
    n_total++; if (div_ctr !== '0) $display("FAIL rst_div_ctr: got %0d expected 0", div_ctr); else n_pass++;
    n_total++; if (iss_valid !== 1'b0) $display("FAIL rst_iss_valid: got %b expected 0", iss_valid); else n_pass++;
    n_total++; if (q_deq_sel !== 4'b0001) $display("FAIL rst_div_eligible: got %b expected 0001", q_deq_sel); else n_pass++;
    tick();
    qe[0] = '0;
    q_count = '0;
    #1;
    n_total++; if (iss_valid !== 1'b1 || iiq_entry_t'(iss_data) !== d3) $display("FAIL rst_div_issue: got %b/%h expected 1/%h", iss_valid, iss_data, d3); else n_pass++;
    tick();
  endtask

  task automatic test_enq_patch();
    iiq_entry_t e, exp_e;
    clear_inputs();
    e     = mk(1'b1, 6'd3, 1'b0, 6'd9, FuAlu, 16'h9000);
    exp_e = mk(1'b1, 6'd3, 1'b1, 6'd9, FuAlu, 16'h9000);
    in_enq_valid = 1'b1;
    in_enq_data  = e;
    cdb_valid    = 2'b10;
    cdb_tag      = {6'd9, 6'd0};
    #1;
    n_total++; if (iiq_entry_t'(q_enq_data) !== exp_e) $display("FAIL enq_patch_src2: got %h expected %h", q_enq_data, exp_e); else n_pass++;
    n_total++; if (q_enq_valid !== 1'b1) $display("FAIL enq_valid: got %b expected 1", q_enq_valid); else n_pass++;
    n_total++; if (in_enq_ready !== 1'b1) $display("FAIL enq_ready_hi: got %b expected 1", in_enq_ready); else n_pass++;
    cdb_valid = 2'b01;
    #1;
    n_total++; if (iiq_entry_t'(q_enq_data) !== e) $display("FAIL enq_invalid_bus: got %h expected %h", q_enq_data, e); else n_pass++;
    in_enq_data = mk(1'b0, 6'd12, 1'b0, 6'd13, FuMul, 16'h9001);
    exp_e       = mk(1'b1, 6'd12, 1'b1, 6'd13, FuMul, 16'h9001);
    cdb_valid   = 2'b11;
    cdb_tag     = {6'd12, 6'd13};
    q_enq_ready = 1'b0;
    #1;
    n_total++; if (iiq_entry_t'(q_enq_data) !== exp_e) $display("FAIL enq_patch_both: got %h expected %h", q_enq_data, exp_e); else n_pass++;
    n_total++; if (in_enq_ready !== 1'b0) $display("FAIL enq_ready_lo: got %b expected 0", in_enq_ready); else n_pass++;
    in_enq_valid = 1'b0;
    #1;
    n_total++; if (q_enq_valid !== 1'b0) $display("FAIL enq_valid_lo: got %b expected 0", q_enq_valid); else n_pass++;
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_wakeup_select();
    test_age_priority();
    test_backpressure();
    test_div_occupancy();
    test_flush();
    test_reset_mid_div();
    test_enq_patch();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
